// File: rtl/cnu_min_serial.sv
// cnu_min_serial: serial check-node min finder.
// Accepts one variable-to-check message per accepted beat and tracks the
// smallest value (min1), second smallest value (min2) and the 0-based beat
// position of min1 over a row of 2..CN_DEGREE beats. The row degree is
// latched on the first beat of each row and clamped into [2, CN_DEGREE].
// Optional feature macro: CNU_SIGN_EN. When it is defined, the message MSB
// is a sign bit. Only the magnitude is compared, and out_sign carries the
// XOR of all signs in the row. When it is undefined, the whole message is
// compared as an unsigned value and out_sign stays 0.
module cnu_min_serial #(
  parameter  int QUAN_SIZE = 4,
  parameter  int CN_DEGREE = 8,
  localparam int IDX_W     = $clog2(CN_DEGREE)
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic [IDX_W:0]       cfg_degree,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE-1:0] out_min1,
  output logic [QUAN_SIZE-1:0] out_min2,
  output logic [IDX_W-1:0]     out_min_idx,
  output logic                 out_sign
);

  localparam logic [IDX_W:0] DEG_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] DEG_MIN = (IDX_W+1)'(2);
  localparam logic [IDX_W:0] DEG_MAX = (IDX_W+1)'(CN_DEGREE);
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

`ifdef CNU_SIGN_EN
  localparam logic [QUAN_SIZE-1:0] MIN2_INIT = {1'b0, {(QUAN_SIZE-1){1'b1}}};
`else
  localparam logic [QUAN_SIZE-1:0] MIN2_INIT = '1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;

  logic [QUAN_SIZE-1:0] min1_q;
  logic [QUAN_SIZE-1:0] min2_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     cnt_q;
  logic [IDX_W:0]       deg_q;
  logic                 sign_q;

  logic                 out_valid_q;
  logic [QUAN_SIZE-1:0] out_min1_q;
  logic [QUAN_SIZE-1:0] out_min2_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic                 out_sign_q;

  logic [QUAN_SIZE-1:0] msg_mag;
  logic                 msg_sign;
  logic [IDX_W:0]       deg_clamped;
  logic [QUAN_SIZE-1:0] nxt_min1;
  logic [QUAN_SIZE-1:0] nxt_min2;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 nxt_sign;
  logic                 last_beat;

  // Split the incoming message into the compared value and its sign bit.
  always_comb begin
`ifdef CNU_SIGN_EN
    msg_mag  = {1'b0, in_msg[QUAN_SIZE-2:0]};
    msg_sign = in_msg[QUAN_SIZE-1];
`else
    msg_mag  = in_msg;
    msg_sign = 1'b0;
`endif
  end

  // Clamp the requested row degree into the supported range.
  always_comb begin
    deg_clamped = cfg_degree;
    if (cfg_degree < DEG_MIN) begin
      deg_clamped = DEG_MIN;
    end else if (cfg_degree > DEG_MAX) begin
      deg_clamped = DEG_MAX;
    end
  end

  // Fold the current beat into the running minima. Strict compares keep the earliest index on ties.
  always_comb begin
    nxt_min1 = min1_q;
    nxt_min2 = min2_q;
    nxt_idx  = idx_q;
    if (msg_mag < min1_q) begin
      nxt_min2 = min1_q;
      nxt_min1 = msg_mag;
      nxt_idx  = cnt_q;
    end else if (msg_mag < min2_q) begin
      nxt_min2 = msg_mag;
    end
    nxt_sign  = sign_q ^ msg_sign;
    last_beat = ({1'b0, cnt_q} == (deg_q - DEG_ONE));
  end

  // Accept input while collecting a row, or in HOLD once the held result is being taken.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      ACC:     in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & rstn;
  end

  // Row FSM: accumulate the beats, then publish the result on entry to HOLD and hold it until it is accepted.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      min1_q      <= '0;
      min2_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      deg_q       <= DEG_MIN;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_min1_q  <= '0;
      out_min2_q  <= '0;
      out_idx_q   <= '0;
      out_sign_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            min1_q <= msg_mag;
            min2_q <= MIN2_INIT;
            idx_q  <= '0;
            cnt_q  <= CNT_ONE;
            deg_q  <= deg_clamped;
            sign_q <= msg_sign;
            state  <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            min1_q <= nxt_min1;
            min2_q <= nxt_min2;
            idx_q  <= nxt_idx;
            sign_q <= nxt_sign;
            cnt_q  <= cnt_q + CNT_ONE;
            if (last_beat) begin
              out_valid_q <= 1'b1;
              out_min1_q  <= nxt_min1;
              out_min2_q  <= nxt_min2;
              out_idx_q   <= nxt_idx;
              out_sign_q  <= nxt_sign;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              min1_q <= msg_mag;
              min2_q <= MIN2_INIT;
              idx_q  <= '0;
              cnt_q  <= CNT_ONE;
              deg_q  <= deg_clamped;
              sign_q <= msg_sign;
              state  <= ACC;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_min1    = out_min1_q;
  assign out_min2    = out_min2_q;
  assign out_min_idx = out_idx_q;
  assign out_sign    = out_sign_q;

endmodule

// File: doc/cnu_min_serial.md
# cnu_min_serial

Serial, parametrised successor to the fixed-degree combinational CNU min finders. It accepts one variable-to-check message per cycle over a valid/ready stream and accumulates min1, min2 and the min1 index. It supports a per-row check-node degree from 2 up to CN_DEGREE, so one instance covers the degree-6 and degree-8 rows of the layered decoder. It sits between the VNU message fetch and the CNU output/compare stage.

## Interface
- QUAN_SIZE, 4: message width in bits.
- CN_DEGREE, 8: maximum check-node degree; IDX_W = $clog2(CN_DEGREE) is derived.
- sys_clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- cfg_degree  in  IDX_W+1  row degree; sampled only on the first beat of a row.
- in_valid  in  1  input message valid.
- in_ready  out  1  block can accept an input message.
- in_msg  in  QUAN_SIZE  input message.
- out_valid  out  1  row result valid.
- out_ready  in  1  downstream accepts the result.
- out_min1  out  QUAN_SIZE  smallest message of the row.
- out_min2  out  QUAN_SIZE  second smallest message of the row.
- out_min_idx  out  IDX_W  beat position (0-based) of min1 within the row.
- out_sign  out  1  XOR of all sign bits in the row; 0 when CNU_SIGN_EN is absent.

## Operation
- FSM has three states: IDLE, ACC and HOLD.
- **IDLE:** in_ready=1. On in_valid:
  - min1=msg, min2=all-ones, idx=0, cnt=1.
  - Latch deg = clamp(cfg_degree, 2, CN_DEGREE).
  - Go to ACC.
- **ACC:** in_ready=1. On each accepted beat:
  - If msg < min1: min2=min1, min1=msg, idx=cnt.
  - Else if msg < min2: min2=msg.
  - Then cnt++.
  - The beat with cnt==deg-1 moves the FSM to HOLD.
- **Ties:** comparisons are strict. An equal value never replaces min1, so the lowest index wins. A value equal to min1 that arrives later fills min2 if it is smaller than the current min2.
- **HOLD:** out_valid=1 and the outputs are stable.
  - If out_ready=0: in_ready=0.
  - If out_ready=1: in_ready=1. A same-cycle in_valid is treated as the first beat of the next row (IDLE actions), with the FSM going to ACC. Otherwise the FSM goes to IDLE.
- Output registers change only on a HOLD entry. cfg_degree changes mid-row are ignored.
- deg==2 is legal and gives exactly 2 beats per row.

## Timing
- Reset values:
  - State is IDLE.
  - in_ready=0 during reset; it reads 1 from the first cycle after deassertion.
  - out_valid=0, out_min1=0, out_min2=0, out_min_idx=0, out_sign=0.
  - cnt=0, deg=2.
- **Latency:** out_valid rises in the cycle after the last beat is accepted.
- **Throughput:** one row per deg cycles with no bubbles, provided out_ready=1 in HOLD.
- **Output back-pressure:** out_valid holds with stable data until out_ready. No beat is accepted while HOLD is stalled.
- **Input stalls:** in_valid=0 mid-row freezes cnt and the accumulators, with no timeout.
- **Reset mid-row:** the partial row is discarded. No out_valid is produced for it.

## Configuration
- **CNU_SIGN_EN defined:**
  - in_msg[QUAN_SIZE-1] is a sign bit.
  - Comparisons use only in_msg[QUAN_SIZE-2:0].
  - out_min1 and out_min2 carry the magnitude with MSB=0; the min2 init value is all-ones magnitude.
  - out_sign is the XOR of all row signs and is cleared at each row start.
- **CNU_SIGN_EN undefined:**
  - The full QUAN_SIZE bits are an unsigned label compared whole.
  - out_sign is tied to 0.

## Test plan
All cases use QUAN_SIZE=4, CN_DEGREE=8, with CNU_SIGN_EN undefined unless stated.
- **Degree-8 row:** deg=8, msgs 9,3,7,12,3,5,1,8, out_ready=1 → min1=1, min2=3, idx=6; out_valid one cycle after beat 7.
- **Degree-6 back-to-back rows:** rows {4,4,10,2,6,11} and {0,15,15,15,15,15} with no gaps → results (2,4,3) then (0,15,0); no idle cycle between rows.
- **Ties:** deg=6, all msgs=5 → min1=5, min2=5, idx=0.
- **Output stall:** out_ready=0 for 5 cycles in HOLD with in_valid=1 → in_ready=0 and outputs stable. Releasing out_ready → the next first beat is accepted in the same cycle.
- **Clamping and reset:** cfg_degree=1 gives a 2-beat row with msgs {7,2} → (2,7,1). rstn pulsed after 3 beats of a deg-8 row → no out_valid, and the next row's results are correct.
- **Sign mode (CNU_SIGN_EN):** deg=4, msgs 4'b1011, 4'b0010, 4'b1110, 4'b0101 → min1=2, min2=3, idx=1, out_sign=0.
